// File: rtl/cdc_vector_handshake_tx.sv
// cdc_vector_handshake_tx: source side of a 4-phase req/ack vector crossing with a one-word pending buffer
module cdc_vector_handshake_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clear
);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam int TL = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic ack_s, pend_valid, hold;
  logic [DATA_WIDTH-1:0] pend_data;
  logic [CW-1:0] cnt;
  always_comb begin
    ack_s = sync[SYNC_STAGES-1];
    hold = (state == REQ_HI) ? !ack_s : (state == REQ_LO) ? ack_s : 1'b0;
    in_ready = !pend_valid && !reset;
    busy = (state != IDLE) || pend_valid;
  end
  // hold is low in IDLE and on every phase change, so it doubles as the counter clear
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      sync <= '0;
      pend_valid <= 1'b0;
      pend_data <= '0;
      req_out <= 1'b0;
      data_out <= '0;
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ack_in};
      if (in_valid && in_ready) begin
        pend_valid <= 1'b1;
        pend_data <= in_data;
      end
      cnt <= !hold ? '0 : (cnt == '1) ? cnt : cnt + 1'b1;
      if (TIMEOUT != 0 && hold && cnt == CW'(TL)) timeout_err <= 1'b1;
      else if (err_clear) timeout_err <= 1'b0;
      case (state)
        IDLE: if (pend_valid && !ack_s) begin
          data_out <= pend_data;
          pend_valid <= 1'b0;
          req_out <= 1'b1;
          state <= REQ_HI;
        end
        REQ_HI: if (ack_s) begin
          req_out <= 1'b0;
          state <= REQ_LO;
        end
        REQ_LO: if (!ack_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cdc_vector_handshake_tx.sv
// tb_cdc_vector_handshake_tx: directed and random-latency checks of the handshake transmitter
module tb_cdc_vector_handshake_tx;
  logic clk = 0, reset = 1, in_valid = 0, err_clear = 0;
  logic [7:0] in_data = 0;
  logic in_ready, req_out, busy, timeout_err, ack_in;
  logic [7:0] data_out;
  logic far_en = 0, rnd = 0, ack_force = 0, ack_m = 0;
  logic prev_req = 0;
  logic [7:0] prev_data = 0;
  int passed = 0, total = 0, viol = 0, acnt = 0, dly_r = 0;
  logic [7:0] got_q[$], exp_q[$];

  assign ack_in = far_en ? ack_m : ack_force;

  cdc_vector_handshake_tx #(.DATA_WIDTH(8), .SYNC_STAGES(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req_out(req_out), .data_out(data_out), .ack_in(ack_in), .busy(busy),
    .timeout_err(timeout_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // far-side endpoint plus 4-phase protocol monitor
  always @(negedge clk) begin
    if (prev_req && req_out && data_out != prev_data) viol++;
    if (far_en && !prev_req && req_out && ack_in) viol++;
    if (far_en && prev_req && !req_out && !ack_in) viol++;
    prev_req = req_out;
    prev_data = data_out;
    if (!far_en) begin
      ack_m = 1'b0;
      acnt = 0;
    end else if (req_out != ack_m) begin
      if (acnt >= (rnd ? dly_r : 3)) begin
        ack_m = req_out;
        if (req_out) got_q.push_back(data_out);
        acnt = 0;
        dly_r = $urandom_range(0, 20);
      end else acnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] v);
    int n = 0;
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    chk("push_rdy", in_ready, 1);
    in_valid = 1;
    in_data = v;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!req_out && n < 2000) begin @(negedge clk); n++; end
    chk(tag, req_out, 1);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_req", req_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    reset = 0;
    #1 chk("rel_ready", in_ready, 1);
    @(negedge clk);

    far_en = 1;
    got_q.delete();
    in_valid = 1;
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 0;
    chk("one_req_lo", req_out, 0);
    chk("one_busy", busy, 1);
    chk("one_full", in_ready, 0);
    @(negedge clk);
    chk("one_req_hi", req_out, 1);
    chk("one_data", data_out, 8'hA5);
    begin
      int n = 0;
      while (req_out && n < 2000) begin @(negedge clk); n++; end
    end
    chk("one_req_fall", req_out, 0);
    chk("one_data_lo", data_out, 8'hA5);
    wait_idle("one_idle");
    chk("one_held", data_out, 8'hA5);
    chk("one_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("one_word", got_q[0], 8'hA5);

    got_q.delete();
    in_valid = 1;
    for (int i = 1; i <= 3; i++) begin
      int n = 0;
      in_data = 8'(i);
      while (!in_ready && n < 2000) begin @(negedge clk); n++; end
      @(negedge clk);
      chk("b2b_full", in_ready, 0);
    end
    in_valid = 0;
    wait_idle("b2b_idle");
    chk("b2b_cnt", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) chk("b2b_word", got_q[i], i + 1);

    far_en = 0;
    ack_force = 1;
    got_q.delete();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    push(8'h5A);
    repeat (6) @(negedge clk);
    chk("stale_hold", req_out, 0);
    chk("stale_busy", busy, 1);
    ack_force = 0;
    repeat (3) @(negedge clk);
    chk("stale_sync", req_out, 0);
    @(negedge clk);
    chk("stale_go", req_out, 1);
    chk("stale_data", data_out, 8'h5A);
    far_en = 1;
    wait_idle("stale_idle");
    chk("stale_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("stale_word", got_q[0], 8'h5A);

    far_en = 0;
    got_q.delete();
    chk("to_pre", timeout_err, 0);
    push(8'h77);
    @(negedge clk);
    chk("to_req", req_out, 1);
    repeat (15) @(negedge clk);
    chk("to_early", timeout_err, 0);
    @(negedge clk);
    chk("to_fire", timeout_err, 1);
    chk("to_hold", req_out, 1);
    far_en = 1;
    wait_idle("to_idle");
    chk("to_word", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h77);
    chk("to_sticky", timeout_err, 1);
    err_clear = 1;
    @(negedge clk);
    err_clear = 0;
    chk("to_clear", timeout_err, 0);

    far_en = 0;
    got_q.delete();
    push(8'h11);
    wait_req("rm_req");
    push(8'h22);
    chk("rm_pend", in_ready, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rm_req_lo", req_out, 0);
    chk("rm_busy", busy, 0);
    chk("rm_ready", in_ready, 1);
    far_en = 1;
    repeat (10) @(negedge clk);
    chk("rm_quiet", req_out, 0);
    chk("rm_none", got_q.size(), 0);
    push(8'h33);
    wait_idle("rm_idle");
    chk("rm_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("rm_word", got_q[0], 8'h33);

    got_q.delete();
    exp_q.delete();
    rnd = 1;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      exp_q.push_back(v);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(v);
    end
    wait_idle("rnd_idle");
    chk("rnd_cnt", got_q.size(), 1000);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("rnd_word", got_q[i], exp_q[i]);
    chk("proto", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
